// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file slave.
// Response codes, channel FSM states and the data width.
package axi4_lite_pkg;

  localparam int AXIL_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register array with byte-strobe merge and per-register write pulse.
// Ports: clk/rst, write port (we/widx/wstrb/wdata), read port (ridx/rdata), q, wr_pulse.
module axil_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [IDX_W-1:0]                widx,
  input  logic [3:0]                      wstrb,
  input  logic [AXIL_DATA_W-1:0]          wdata,
  input  logic [IDX_W-1:0]                ridx,
  output logic [AXIL_DATA_W-1:0]          rdata,
  output logic [NUM_REGS*AXIL_DATA_W-1:0] q,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) begin
            regs[widx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
        // An all-zero strobe changes nothing, so it is not reported.
        if (wstrb != 4'b0000) begin
          wr_pulse[widx] <= 1'b1;
        end
      end
    end
  end

  assign rdata = (32'(ridx) < NUM_REGS) ? regs[ridx] : '0;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
    assign q[AXIL_DATA_W*k +: AXIL_DATA_W] = regs[k];
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave fronting NUM_REGS 32-bit control registers.
// Ports: S_AXI AW/W/B/AR/R channels, reg_q contents, reg_wr_pulse strobes.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic [NUM_REGS-1:0]    reg_wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS * 4);

  wr_state_t wst, wst_n;
  rd_state_t rd_st, rd_st_n;

  // Held low for the first cycle after reset so every output reads 0.
  logic up;

  logic [ADDR_W-1:0] aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  resp_t             bresp_q;
  resp_t             rresp_q;
  logic [31:0]       rdata_q;
  logic [31:0]       bank_rdata;

  logic aw_hs, w_hs, ar_hs;
  logic aw_ok, ar_ok;

  assign S_AXI_AWREADY = up && (wst == W_IDLE || wst == W_HAVE_W);
  assign S_AXI_WREADY  = up && (wst == W_IDLE || wst == W_HAVE_AW);
  assign S_AXI_BVALID  = (wst == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = up && (rd_st == R_IDLE);
  assign S_AXI_RVALID  = (rd_st == R_RESP);
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign aw_ok = aw_addr < LIMIT;
  assign ar_ok = S_AXI_ARADDR < LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      wst   <= W_IDLE;
      rd_st <= R_IDLE;
      up    <= 1'b0;
    end else begin
      wst   <= wst_n;
      rd_st <= rd_st_n;
      up    <= 1'b1;
    end
  end

  always_comb begin
    wst_n = wst;
    unique case (wst)
      W_IDLE: begin
        if (aw_hs && w_hs) wst_n = W_COMMIT;
        else if (aw_hs)    wst_n = W_HAVE_AW;
        else if (w_hs)     wst_n = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wst_n = W_COMMIT;
      W_HAVE_W:  if (aw_hs) wst_n = W_COMMIT;
      W_COMMIT:  wst_n = W_RESP;
      W_RESP:    if (S_AXI_BREADY) wst_n = W_IDLE;
      default:   wst_n = W_IDLE;
    endcase
  end

  always_comb begin
    rd_st_n = rd_st;
    unique case (rd_st)
      R_IDLE:  if (ar_hs) rd_st_n = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rd_st_n = R_IDLE;
      default: rd_st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_q <= OKAY;
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else begin
      if (aw_hs) aw_addr <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (wst == W_COMMIT) begin
        bresp_q <= aw_ok ? OKAY : SLVERR;
      end
      // Sampled before the commit edge lands, so a same-cycle write
      // to this register is not yet visible.
      if (ar_hs) begin
        rdata_q <= ar_ok ? bank_rdata : '0;
        rresp_q <= ar_ok ? OKAY : SLVERR;
      end
    end
  end

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       ((wst == W_COMMIT) && aw_ok),
    .widx     (aw_addr[IDX_W+1:2]),
    .wstrb    (w_strb),
    .wdata    (w_data),
    .ridx     (S_AXI_ARADDR[IDX_W+1:2]),
    .rdata    (bank_rdata),
    .q        (reg_q),
    .wr_pulse (reg_wr_pulse)
  );

endmodule
